// File: rtl/alu_byte_sequencer.sv
// alu_byte_sequencer: runs NBYTES-wide ops on an 8-bit ALU one byte per clock.
// Define ALU_SEQ_OVF_EN to add the signed-overflow output ovf.
module alu_byte_sequencer #(
    parameter int NBYTES = 4,
    localparam int WW = 8 * NBYTES
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic [2:0]    op_sel,
    input  logic [WW-1:0] opA,
    input  logic [WW-1:0] opB,
    output logic          busy,
    output logic          done,
    output logic [WW-1:0] result,
    output logic          carry_out,
`ifdef ALU_SEQ_OVF_EN
    output logic          ovf,
`endif
    output logic [3:0]    alu_op,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic          alu_cin,
    input  logic [7:0]    alu_out,
    input  logic          alu_cout
);
    localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_RSH = 3'd3;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WW-1:0] a_q, b_q;
    logic [2:0] op_q;
    logic [IW-1:0] idx;
    logic carry, sub, chain, last;
    logic [7:0] a_byte, b_byte;
`ifdef ALU_SEQ_OVF_EN
    logic ovf_nx;
`endif
    always_comb begin
        a_byte = a_q[idx*8 +: 8];
        b_byte = b_q[idx*8 +: 8];
        sub = op_q == OP_SUB;
        // only arithmetic and shifts propagate a bit between slices
        chain = op_q <= OP_RSH;
        last = op_q == OP_RSH ? idx == '0 : idx == IW'(NBYTES - 1);
        state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
        busy = state != IDLE;
        done = state == DONE;
        alu_op = state == RUN && !sub ? {1'b0, op_q} : 4'd0;
        alu_a = state == RUN ? a_byte : 8'd0;
        alu_b = state == RUN ? (sub ? ~b_byte : b_byte) : 8'd0;
        alu_cin = state == RUN && chain && carry;
`ifdef ALU_SEQ_OVF_EN
        ovf_nx = (op_q == OP_ADD || sub) && a_q[WW-1] == (b_q[WW-1] ^ sub) && alu_out[7] != a_q[WW-1];
`endif
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            a_q <= '0;
            b_q <= '0;
            op_q <= OP_ADD;
            idx <= '0;
            carry <= 1'b0;
            result <= '0;
            carry_out <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                a_q <= opA;
                b_q <= opB;
                op_q <= op_sel;
                result <= '0;
                carry <= op_sel == OP_SUB;
                idx <= op_sel == OP_RSH ? IW'(NBYTES - 1) : '0;
            end else if (state == RUN) begin
                result[idx*8 +: 8] <= alu_out;
                carry <= chain & alu_cout;
                idx <= op_q == OP_RSH ? idx - IW'(1) : idx + IW'(1);
                if (last) begin
                    carry_out <= chain & alu_cout;
`ifdef ALU_SEQ_OVF_EN
                    ovf <= ovf_nx;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_byte_sequencer.sv
// tb_alu_byte_sequencer: random and directed checks against a word-level model.
module tb_alu_byte_sequencer;
    localparam int NB = 4;
    logic Clk = 1'b0, Reset, start;
    logic [2:0] op_sel;
    logic [31:0] opA, opB, result;
    logic busy, done, carry_out, alu_cin, alu_cout;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [8:0] sum9;
`ifdef ALU_SEQ_OVF_EN
    logic ovf;
`endif
    int total = 0, bad = 0;

    alu_byte_sequencer #(.NBYTES(NB)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .op_sel(op_sel), .opA(opA), .opB(opB),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
`ifdef ALU_SEQ_OVF_EN
        .ovf(ovf),
`endif
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout)
    );

    always #5 Clk = ~Clk;

    // 8-bit combinational ALU the sequencer drives
    always_comb begin
        sum9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        alu_out = 8'd0;
        alu_cout = 1'b0;
        case (alu_op)
            4'd0: {alu_cout, alu_out} = sum9;
            4'd2: {alu_cout, alu_out} = {alu_a, alu_cin};
            4'd3: {alu_out, alu_cout} = {alu_cin, alu_a};
            4'd4: alu_out = alu_a ^ alu_b;
            4'd5: alu_out = alu_a & alu_b;
            4'd6: alu_out = alu_a | alu_b;
            default: alu_out = 8'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic c, output logic v);
        logic [32:0] s;
        logic [31:0] bb;
        bb = op == 3'd1 ? ~b : b;
        s = {1'b0, a} + {1'b0, bb} + {32'd0, op == 3'd1};
        r = 32'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                {c, r} = s;
                v = a[31] == bb[31] && r[31] != a[31];
            end
            3'd2: {c, r} = {a, 1'b0};
            3'd3: {r, c} = {1'b0, a};
            3'd4: r = a ^ b;
            3'd5: r = a & b;
            3'd6: r = a | b;
            default: r = 32'd0;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit poke, input bit trace);
        logic [31:0] er;
        logic ec, ev;
        logic [7:0] seen [NB];
        int lat = 0, bcnt = 0, n = 0;
        ref_op(op, a, b, er, ec, ev);
        @(negedge Clk);
        op_sel = op; opA = a; opB = b; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0; opA = $urandom; opB = $urandom; op_sel = 3'($urandom);
        for (int c = 1; c <= 20; c++) begin
            if (busy) bcnt++;
            if (busy && !done && n < NB) begin seen[n] = alu_a; n++; end
            if (done) begin lat = c; break; end
            if (poke) start = c == 2;
            @(posedge Clk); #1;
        end
        start = 1'b0;
        chk($sformatf("lat op%0d", op), 64'(lat), 64'(NB + 1));
        chk($sformatf("busy op%0d", op), 64'(bcnt), 64'(NB + 1));
        chk($sformatf("result op%0d a=%h b=%h", op, a, b), 64'(result), 64'(er));
        chk($sformatf("carry op%0d a=%h b=%h", op, a, b), 64'(carry_out), 64'(ec));
`ifdef ALU_SEQ_OVF_EN
        chk($sformatf("ovf op%0d a=%h b=%h", op, a, b), 64'(ovf), 64'(ev));
`endif
        if (trace)
            for (int k = 0; k < NB; k++)
                chk($sformatf("alu_a slice%0d op%0d", k, op), 64'(seen[k]),
                    64'(op == 3'd3 ? a[(NB-1-k)*8 +: 8] : a[k*8 +: 8]));
        @(posedge Clk); #1;
        chk("done pulse", 64'({done, busy}), 64'd0);
        chk("idle drive", 64'({alu_op, alu_a, alu_b, alu_cin}), 64'd0);
        chk("result hold", 64'(result), 64'(er));
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; op_sel = 3'd0; opA = 32'd0; opB = 32'd0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst state", 64'({busy, done, carry_out}), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
        run_op(3'd1, 32'h0000_0000, 32'h0000_0001, 0, 0);
        run_op(3'd1, 32'h1234_5678, 32'h0234_5670, 0, 0);
        run_op(3'd2, 32'h8000_0001, 32'hDEAD_BEEF, 0, 1);
        run_op(3'd3, 32'h8000_0001, 32'hDEAD_BEEF, 0, 1);
        run_op(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 0);
        run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0);
        run_op(3'd1, 32'h8000_0000, 32'h0000_0001, 0, 0);
        run_op(3'd0, 32'h0000_0001, 32'h0000_0001, 0, 0);
        // async reset in the second RUN cycle of an ADD
        @(negedge Clk);
        op_sel = 3'd0; opA = 32'h0101_0101; opB = 32'h0101_0101; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        @(posedge Clk); #2;
        Reset = 1'b1;
        #1;
        chk("midrst flags", 64'({busy, done, carry_out}), 64'd0);
        chk("midrst result", 64'(result), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        run_op(3'd0, 32'd3, 32'd4, 0, 0);
        for (int i = 0; i < 40; i++)
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom, ($urandom & 1) != 0, i < 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_byte_sequencer.md
Name: alu_byte_sequencer

Overview:
- Multi-cycle controller that runs wide (NBYTES×8-bit) arithmetic, logic and shift operations on the team's single 8-bit combinational ALU, one byte slice per clock.
- Chains carry/shift bits between byte slices.
- Sits between the core's execute stage and the ALU instance; drives the ALU's opcode, operand and carry-in, and captures its output and carry-out.
- The ALU instance exposes its shift/carry bit as explicit carry-in and carry-out ports.

Parameters:
- NBYTES, 4, operand width in bytes (legal range 1 to 16); word width WW = 8*NBYTES.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op_sel  in  3  0 ADD, 1 SUB, 2 LSH, 3 RSH, 4 XOR, 5 AND, 6 OR, 7 CLR.
- opA  in  WW  operand A; latched on accept.
- opB  in  WW  operand B; latched on accept, ignored by shifts and CLR.
- busy  out  1  high from the cycle after accept through the DONE cycle.
- done  out  1  one-cycle pulse; result is valid.
- result  out  WW  final word; held until the next accept.
- carry_out  out  1  final carry/borrow/shifted-out bit.
- alu_op  out  4  ALU opcode, using Definitions encodings.
- alu_a  out  8  ALU InputA byte.
- alu_b  out  8  ALU InputB byte.
- alu_cin  out  1  ALU carry/shift-in.
- alu_out  in  8  ALU Out byte.
- alu_cout  in  1  ALU carry/shift-out.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; busy=0, done=0, result=0, carry_out=0, byte index=0, carry register=0. Any partial operation is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when start=1. Latch opA, opB and op_sel. Clear the result accumulator.
  - Set the carry register to 1 for SUB and 0 for all other ops.
  - Byte index starts at 0 for ADD/SUB/LSH/logic/CLR (LSB first) and at NBYTES-1 for RSH (MSB first).
- RUN, one byte slice per cycle. The ALU path is combinational.
  - At each edge: write alu_out into result byte [idx], write alu_cout into the carry register, then step idx (+1, or -1 for RSH).
  - After NBYTES slices, go to DONE.
- DONE: done=1 for exactly one cycle; carry_out = carry register; then return to IDLE.
- Latency: start accepted at edge 0 → done high in cycle NBYTES+1; next accept is possible at edge NBYTES+2.
- start while busy: ignored, not queued. opA, opB and op_sel changes after accept have no effect.
- ALU drive per op:
  - ADD: alu_op=ADD, a=A[idx], b=B[idx], cin=carry.
  - SUB: alu_op=ADD, b=~B[idx], cin=carry (first slice cin=1). carry_out=1 means no borrow.
  - LSH: alu_op=LSH, cin=carry (first slice 0). carry_out = original word MSB.
  - RSH: alu_op=RSH, cin=carry (first slice 0). carry_out = original word bit 0.
  - XOR/AND/OR: matching alu_op; alu_cin=0; carry register forced to 0.
  - CLR: alu_op=CLR; result 0; carry_out 0. CLR still takes NBYTES cycles.
- Outside RUN: alu_op=ADD, alu_a=0, alu_b=0, alu_cin=0.
- NBYTES=1: a single RUN cycle; behaviour is otherwise identical.

Optional Feature:
- Macro: ALU_SEQ_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), updated in DONE.
  - ADD: ovf = signed two's-complement overflow of WW-bit A+B, i.e. operand sign bits equal and result sign differs.
  - SUB: same rule using A and ~B.
  - All other ops: ovf=0.
- Undefined: port absent; no extra logic.

Test Plan:
- NBYTES=4, ADD: 0xFFFFFFFF + 0x00000001 → result 0x00000000, carry_out 1; done exactly 5 cycles after the accept edge; busy high 5 cycles.
- SUB: 0x00000000 − 0x00000001 → result 0xFFFFFFFF, carry_out 0. Also 0x12345678 − 0x02345670 → 0x10000008, carry_out 1.
- Shifts on 0x80000001: LSH → 0x00000002, carry_out 1; RSH → 0x40000000, carry_out 1. Check alu_a steps through bytes 0→3 for LSH and 3→0 for RSH.
- XOR 0xF0F0F0F0 with 0xFF00FF00 → 0x0FF00FF0, carry_out 0. Pulse start again during RUN with a different op → ignored; the first result is unchanged.
- Reset in the 2nd RUN cycle of an ADD → busy, done, result and carry_out go 0 immediately. A fresh ADD 3+4 afterwards → 0x00000007, correct latency.
- With ALU_SEQ_OVF_EN: ADD 0x7FFFFFFF + 1 → ovf 1; SUB 0x80000000 − 1 → ovf 1; ADD 1+1 → ovf 0.
